// File: rtl/sum_accumulator_pkg.sv
// Shared types and default sizes for the frame-sum accumulator.
// Holds the three-state FSM encoding used by sum_accumulator.
package sum_accumulator_pkg;

  localparam int WIDTH_DEF = 6;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/RippleCarryAdder.sv
// Combinational ripple-carry adder, SUM = (A + B) mod 2^WIDTH; zero latency, no flow control.
// The final carry-out is not exported; callers recover wrap from the result itself.
module RippleCarryAdder #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] SUM
);

  logic [WIDTH-1:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_carry
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign SUM = A ^ B ^ c;

endmodule

// File: rtl/sum_accumulator.sv
// Sums count operands per frame (valid/ready in, valid/ready out); result valid one cycle after last operand.
// Result holds in DONE until out_ready; in_ready is only offered while collecting operands.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow,
  input  logic             out_ready,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             ovf;
  logic [CNT_W-1:0] remaining;
  logic             xfer;
  logic             carry;
  logic             last_xfer;

  RippleCarryAdder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .A   (acc),
    .B   (in_data),
    .SUM (acc_nxt)
  );

  // An unsigned modular sum wraps exactly when it ends up below its old value.
  assign carry     = (acc_nxt < acc);
  assign xfer      = in_valid && (state == ACCUM);
  assign last_xfer = xfer && (remaining == CNT_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (count == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (last_xfer) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        acc       <= '0;
        ovf       <= 1'b0;
        remaining <= count;
      end else if (xfer) begin
        acc       <= acc_nxt;
        ovf       <= ovf | carry;
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  assign in_ready     = (state == ACCUM);
  assign out_valid    = (state == DONE);
  assign busy         = (state != IDLE);
  assign out_sum      = acc;
  assign out_overflow = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: an integer-arithmetic frame model is compared every
// cycle, and each scenario also pins hand-computed literal results.
module tb_sum_accumulator;

  localparam int MOD = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] count;
  logic       in_valid;
  logic [5:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [5:0] out_sum;
  logic       out_overflow;
  logic       out_ready;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Frame model: 0 = waiting for start, 1 = collecting operands, 2 = presenting result.
  int m_phase = 0;
  int m_left  = 0;
  int m_total = 0;
  bit m_wrap  = 1'b0;

  sum_accumulator #(
    .WIDTH (6),
    .CNT_W (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .count        (count),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_left  = 0;
      m_total = 0;
      m_wrap  = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_total = 0;
          m_wrap  = 1'b0;
          m_left  = int'(count);
          m_phase = (count == 4'd0) ? 2 : 1;
        end
        1: if (in_valid) begin
          if (m_total + int'(in_data) >= MOD) m_wrap = 1'b1;
          m_total = (m_total + int'(in_data)) % MOD;
          m_left  = m_left - 1;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("cyc_in_ready",  int'(in_ready),     int'(m_phase == 1));
    check("cyc_out_valid", int'(out_valid),    int'(m_phase == 2));
    check("cyc_busy",      int'(busy),         int'(m_phase != 0));
    check("cyc_out_sum",   int'(out_sum),      m_total);
    check("cyc_overflow",  int'(out_overflow), int'(m_wrap));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame(input int n);
    start = 1'b1;
    count = 4'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int v, input int gap);
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = 6'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    check(name, int'(out_valid), 1);
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check(name, int'(busy), 0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    count     = 4'd0;
    in_valid  = 1'b0;
    in_data   = 6'd0;
    out_ready = 1'b0;
    tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready",  int'(in_ready),  0);
    check("rst_busy",      int'(busy),      0);
    check("rst_out_sum",   int'(out_sum),   0);
    tick();
    reset = 1'b0;

    // 3 + 11 = 14, result valid the cycle after the last operand
    start_frame(2);
    send(3, 0);
    send(11, 0);
    check("s1_latency", int'(out_valid), 1);
    check("s1_sum", int'(out_sum), 14);
    check("s1_ovf", int'(out_overflow), 0);
    release_result("s1_idle");

    // 40 + 30 = 70 -> 6 with wrap
    start_frame(2);
    send(40, 0);
    send(30, 0);
    wait_done("s2_done");
    check("s2_sum", int'(out_sum), 6);
    check("s2_ovf", int'(out_overflow), 1);
    release_result("s2_idle");

    // empty frame goes straight to a cleared result
    start_frame(0);
    check("s3_valid", int'(out_valid), 1);
    check("s3_sum", int'(out_sum), 0);
    check("s3_ovf", int'(out_overflow), 0);
    release_result("s3_idle");

    // gaps between operands, then a held result under backpressure
    start_frame(3);
    send(1, 2);
    send(2, 2);
    send(3, 2);
    check("s4_valid", int'(out_valid), 1);
    repeat (5) begin
      tick();
      check("s4_hold_sum", int'(out_sum), 6);
      check("s4_hold_valid", int'(out_valid), 1);
    end
    release_result("s4_idle");
    check("s4_out_valid_low", int'(out_valid), 0);

    // reset in the middle of a frame
    start_frame(4);
    send(50, 0);
    send(20, 0);
    check("s5_pre_ovf", int'(out_overflow), 1);
    reset = 1'b1;
    #1;
    check("s5_rst_sum", int'(out_sum), 0);
    check("s5_rst_ovf", int'(out_overflow), 0);
    check("s5_rst_in_ready", int'(in_ready), 0);
    check("s5_rst_busy", int'(busy), 0);
    check("s5_rst_valid", int'(out_valid), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    start_frame(1);
    check("s5_first_start", int'(in_ready), 1);
    send(5, 0);
    check("s5_valid", int'(out_valid), 1);
    check("s5_sum", int'(out_sum), 5);
    release_result("s5_idle");

    // start pulses while busy must not disturb the frame
    start_frame(2);
    send(7, 0);
    start = 1'b1;
    count = 4'd5;
    tick();
    start = 1'b0;
    check("s6_still_accum", int'(in_ready), 1);
    send(8, 0);
    check("s6_valid", int'(out_valid), 1);
    start = 1'b1;
    count = 4'd0;
    tick();
    start = 1'b0;
    check("s6_done_sum", int'(out_sum), 15);
    check("s6_done_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    start     = 1'b1;
    count     = 4'd3;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("s6_release_idle", int'(busy), 0);
    tick();
    check("s6_start_ignored", int'(busy), 0);

    // longest frame: 15 x 4 = 60, no wrap
    start_frame(15);
    for (int i = 0; i < 15; i++) send(4, i % 2);
    wait_done("s7_done");
    check("s7_sum", int'(out_sum), 60);
    check("s7_ovf", int'(out_overflow), 0);
    release_result("s7_idle");

    // exact 2^WIDTH boundary: 63 + 1 = 0 with wrap
    start_frame(2);
    send(63, 0);
    send(1, 0);
    check("s8_sum", int'(out_sum), 0);
    check("s8_ovf", int'(out_overflow), 1);
    release_result("s8_idle");

    // overflow stays set after a later non-wrapping add: 60 + 10 + 1 = 7
    start_frame(3);
    send(60, 0);
    send(10, 1);
    send(1, 0);
    wait_done("s9_done");
    check("s9_sum", int'(out_sum), 7);
    check("s9_ovf", int'(out_overflow), 1);
    release_result("s9_idle");

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter: WIDTH, 6, operand and sum width in bits.
REQ-002 Parameter: CNT_W, 4, width of the operand-count field.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse that begins a frame; sampled only in IDLE.
REQ-006 count  input  CNT_W  number of operands in the frame, 0..15; sampled with start.
REQ-007 in_valid  input  1  in_data holds a valid operand.
REQ-008 in_data  input  WIDTH  unsigned operand.
REQ-009 in_ready  output  1  block accepts an operand this cycle.
REQ-010 out_valid  output  1  result is available.
REQ-011 out_sum  output  WIDTH  accumulated sum, modulo 2^WIDTH.
REQ-012 out_overflow  output  1  sticky flag: at least one addition in the frame wrapped.
REQ-013 out_ready  input  1  downstream consumes the result.
REQ-014 busy  output  1  high in ACCUM and DONE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-016 In IDLE with start=1 and count!=0, the block SHALL clear acc and ovf, load remaining=count, and go to ACCUM.
REQ-017 In IDLE with start=1 and count=0, the block SHALL clear acc and ovf and go directly to DONE.
REQ-018 start SHALL be ignored in ACCUM and DONE.
REQ-019 in_ready SHALL be 1 only in ACCUM.
REQ-020 A transfer occurs when in_valid and in_ready are both 1 in the same cycle.
REQ-021 On each transfer: acc <= (acc + in_data) mod 2^WIDTH, ovf <= ovf | carry, remaining <= remaining - 1.
REQ-022 The carry SHALL be 1 when the true sum is >= 2^WIDTH (equivalently, when the new acc < old acc).
REQ-023 A transfer with remaining=1 SHALL move the FSM to DONE; out_valid SHALL be high on the next cycle (latency 1).
REQ-024 When in_valid=0 in ACCUM, the block SHALL wait with no state change; gaps of any length are allowed.
REQ-025 In DONE, out_valid SHALL be 1 and out_sum/out_overflow SHALL hold stable until out_ready=1.
REQ-026 DONE with out_ready=1 SHALL return to IDLE on the next edge; a start in that same cycle SHALL be ignored.
REQ-027 out_sum SHALL equal acc and out_overflow SHALL equal ovf in every state.
REQ-028 The addition SHALL be performed by the existing ripple-carry adder; the carry SHALL be derived per REQ-022.

Reset
REQ-029 Asserting reset SHALL immediately force state=IDLE, acc=0, ovf=0 and remaining=0.
REQ-030 The immediate effect of REQ-029 on outputs: in_ready=0, out_valid=0, out_sum=0, out_overflow=0, busy=0.
REQ-031 Reset asserted during ACCUM or DONE SHALL abandon the frame; no partial result is presented after release.
REQ-032 After reset deassertion, the first start SHALL be honoured on the first rising edge.

Structure
REQ-033 The shared package SHALL hold the state enumeration (IDLE, ACCUM, DONE) and the default WIDTH and CNT_W constants.
REQ-034 The only sub-module SHALL be one instance of RippleCarryAdder, with A=acc, B=in_data and SUM=next acc.
REQ-035 The remaining FSM, counter and flag logic SHALL be written inline in sum_accumulator.

Verification
REQ-036 Scenario 1: start with count=2; send operands 3 then 11 -> out_valid=1, out_sum=6'b001110, out_overflow=0.
REQ-037 Scenario 2: count=2; send 40 then 30 -> out_sum=6, out_overflow=1.
REQ-038 Scenario 3: count=0 -> out_valid=1 on the cycle after start, with out_sum=0 and out_overflow=0.
REQ-039 Scenario 4: count=3 with operands 1, 2, 3 and 2-cycle in_valid gaps; hold out_ready=0 for 5 cycles -> out_sum=6 stays stable, then IDLE one cycle after out_ready=1.
REQ-040 Scenario 5: assert reset after the 2nd of 4 operands -> all outputs 0 immediately; a new frame with count=1 and operand 5 -> out_sum=5.
REQ-041 Scenario 6: pulse start during ACCUM and during DONE -> no effect on remaining, acc or the result.
